// File: rtl/kmkz_mem_arbiter_pkg.sv
// rtl/kmkz_mem_arbiter_pkg.sv - shared constants for the memory port arbiter
package kmkz_mem_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        LS_WAIT = 2'd2,
        IF_DROP = 2'd3
    } arb_state_t;

endpackage

// File: rtl/kmkz_arb_timeout.sv
// rtl/kmkz_arb_timeout.sv - bus wait watchdog counter
module kmkz_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    // Count enabled wait cycles; expires on the TIMEOUT_CYCLES-th one
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = en && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/kmkz_mem_arbiter.sv
// rtl/kmkz_mem_arbiter.sv - single-port memory arbiter between fetch and LSU
module kmkz_mem_arbiter
    import kmkz_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            branch_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic [XLEN-1:0] if_data_o,
    output logic            if_ready_o,
    output logic            if_err_o,
    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  logic [3:0]      ls_be_i,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    output logic [XLEN-1:0] ls_rdata_o,
    output logic            ls_ready_o,
    output logic            ls_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    arb_state_t      state, state_d;
    logic [3:0]      starve_cnt, starve_cnt_d;
    logic            if_win, ls_win, tmo_en, tmo_expired;
    logic            mem_req_d, mem_we_d;
    logic [3:0]      mem_be_d;
    logic [XLEN-1:0] mem_addr_d, mem_wdata_d, if_data_d, ls_rdata_d;
    logic            if_ready_d, if_err_d, ls_ready_d, ls_err_d;

    // LSU has priority unless fetch has been passed over STARVE_LIMIT times
    assign if_win = (state == IDLE) && if_req_i && !branch_i
                    && (!ls_req_i || starve_cnt == STARVE_MAX);
    assign ls_win = (state == IDLE) && !if_win && ls_req_i;
    assign tmo_en = (state != IDLE) && !mem_ack_i;

    kmkz_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (if_win || ls_win),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // State, starvation counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_data_o   <= '0;
            if_ready_o  <= 1'b0;
            if_err_o    <= 1'b0;
            ls_rdata_o  <= '0;
            ls_ready_o  <= 1'b0;
            ls_err_o    <= 1'b0;
        end else begin
            state       <= state_d;
            starve_cnt  <= starve_cnt_d;
            mem_req_o   <= mem_req_d;
            mem_we_o    <= mem_we_d;
            mem_be_o    <= mem_be_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            if_data_o   <= if_data_d;
            if_ready_o  <= if_ready_d;
            if_err_o    <= if_err_d;
            ls_rdata_o  <= ls_rdata_d;
            ls_ready_o  <= ls_ready_d;
            ls_err_o    <= ls_err_d;
        end
    end

    // Next state: the bus cannot abort, so a flushed fetch waits in IF_DROP
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (if_win) begin
                    state_d = IF_WAIT;
                end else if (ls_win) begin
                    state_d = LS_WAIT;
                end
            end
            IF_WAIT: begin
                if (mem_ack_i || tmo_expired) begin
                    state_d = IDLE;
                end else if (branch_i) begin
                    state_d = IF_DROP;
                end
            end
            LS_WAIT, IF_DROP: begin
                if (mem_ack_i || tmo_expired) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next values: latch the winner on grant, pulse the owner on completion
    always_comb begin
        starve_cnt_d = starve_cnt;
        mem_req_d    = mem_req_o;
        mem_we_d     = mem_we_o;
        mem_be_d     = mem_be_o;
        mem_addr_d   = mem_addr_o;
        mem_wdata_d  = mem_wdata_o;
        if_data_d    = if_data_o;
        ls_rdata_d   = ls_rdata_o;
        if_ready_d   = 1'b0;
        if_err_d     = 1'b0;
        ls_ready_d   = 1'b0;
        ls_err_d     = 1'b0;
        case (state)
            IDLE: begin
                if (if_win) begin
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = 4'hF;
                    mem_addr_d   = if_addr_i & 32'hFFFF_FFFC;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end else if (ls_win) begin
                    mem_req_d    = 1'b1;
                    mem_we_d     = ls_we_i;
                    mem_be_d     = ls_be_i;
                    mem_addr_d   = ls_addr_i;
                    mem_wdata_d  = ls_wdata_i;
                    if (!if_req_i) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt + 4'd1;
                    end
                end
            end
            IF_WAIT: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (!branch_i) begin
                        if_ready_d = 1'b1;
                        if_data_d  = mem_rdata_i;
                    end
                end else if (tmo_expired) begin
                    mem_req_d = 1'b0;
                    if (!branch_i) begin
                        if_ready_d = 1'b1;
                        if_err_d   = 1'b1;
                    end
                end
            end
            LS_WAIT: begin
                if (mem_ack_i) begin
                    mem_req_d  = 1'b0;
                    ls_ready_d = 1'b1;
                    ls_rdata_d = mem_rdata_i;
                end else if (tmo_expired) begin
                    mem_req_d  = 1'b0;
                    ls_ready_d = 1'b1;
                    ls_err_d   = 1'b1;
                end
            end
            IF_DROP: begin
                if (mem_ack_i || tmo_expired) begin
                    mem_req_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
